out_sched: RTL



---
 rtl/host_pkg.sv | 19 +
 rtl/out_sched_if.sv | 28 ++
 rtl/rr_pick.sv | 31 +++
 rtl/out_sched.sv | 135 +++++++++++++
 4 files changed

// File: rtl/host_pkg.sv
// Shared definitions for the host-side transmit path: scheduler states,
// the tag header base and the source-count ceiling.
package host_pkg;

    localparam logic [7:0] TAG_BASE = 8'hA0;
    localparam int         MAX_SRCS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAG  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    // Header byte announcing which source owns the following burst.
    function automatic logic [7:0] tag_byte(input logic [3:0] idx);
        return TAG_BASE | {4'h0, idx};
    endfunction

endpackage

// File: rtl/out_sched_if.sv
// Producer-side and ft2232-side signals of the output scheduler, bundled as one port.
// Handshakes: a source holds src_req_i while src_data_i is valid; a src_sel_o pulse
// means that byte was consumed this cycle. out_o is valid while out_req_o=1 and is
// taken in any cycle where out_ack_i=1 together with out_req_o=1.
interface out_sched_if
    import host_pkg::*;
#(
    parameter int N_SRCS = 2
);
    logic [8*N_SRCS-1:0] src_data_i;
    logic [N_SRCS-1:0]   src_req_i;
    logic [N_SRCS-1:0]   src_sel_o;
    logic [N_SRCS-1:0]   grant_o;
    logic [7:0]          out_o;
    logic                out_req_o;
    logic                out_ack_i;
    state_t              state_o;

    modport slave (
        input  src_data_i, src_req_i, out_ack_i,
        output src_sel_o, grant_o, out_o, out_req_o, state_o
    );

    modport master (
        output src_data_i, src_req_i, out_ack_i,
        input  src_sel_o, grant_o, out_o, out_req_o, state_o
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: returns the first requester
// found scanning last_i+1, last_i+2, ... modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ) + 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);
    logic [IDX_W-1:0] start;
    logic [N_REQ-1:0] rot;
    logic [IDX_W:0]   off;
    logic [IDX_W:0]   sum;

    always_comb begin
        start = (last_i == IDX_W'(N_REQ - 1)) ? '0 : last_i + IDX_W'(1);
        // Rotate so bit 0 is the highest-priority position.
        rot   = N_REQ'({req_i, req_i} >> start);
        off   = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = (IDX_W + 1)'(j);
            end
        end
        sum   = {1'b0, start} + off;
        idx_o = (sum >= (IDX_W + 1)'(N_REQ)) ? IDX_W'(sum - (IDX_W + 1)'(N_REQ)) : IDX_W'(sum);
        any_o = |req_i;
    end
endmodule

// File: rtl/out_sched.sv
// Round-robin scheduler sharing the ft2232 transmit byte stream between N_SRCS producers.
// Define OUT_SCHED_TAG_EN to prefix every grant with a 0xA0|src header byte.
module out_sched
    import host_pkg::*;
#(
    parameter int N_SRCS    = 2,
    parameter int BURST_MAX = 64
) (
    input  logic       clk_i,
    input  logic       reset_i,
    out_sched_if.slave bus
);
    localparam int IDX_W = $clog2(N_SRCS) + 1;
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    state_t            state_q;
    logic [IDX_W-1:0]  cur_src_q;
    logic [IDX_W-1:0]  last_src_q;
    logic [CNT_W-1:0]  burst_cnt_q;
    logic [N_SRCS-1:0] grant_q;

    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              cur_req;
    logic [7:0]        cur_data;
    logic              last_beat;
    logic              out_req;
    logic [7:0]        out_byte;
    logic [N_SRCS-1:0] sel;

    rr_pick #(
        .N_REQ (N_SRCS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i  (bus.src_req_i),
        .last_i (last_src_q),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    always_comb begin
        cur_req  = 1'b0;
        cur_data = 8'h00;
        for (int k = 0; k < N_SRCS; k++) begin
            if (cur_src_q == IDX_W'(k)) begin
                cur_req  = bus.src_req_i[k];
                cur_data = bus.src_data_i[8*k +: 8];
            end
        end
    end

    assign last_beat = ({1'b0, burst_cnt_q} + (CNT_W + 1)'(1)) == (CNT_W + 1)'(BURST_MAX);

    // Outputs decode registered state plus the owner's request; ack only drives src_sel_o.
    always_comb begin
        out_req  = 1'b0;
        out_byte = 8'h00;
        sel      = '0;
        case (state_q)
`ifdef OUT_SCHED_TAG_EN
            ST_TAG: begin
                out_req  = 1'b1;
                out_byte = tag_byte(4'(cur_src_q));
            end
`endif
            ST_SEND: begin
                if (cur_req) begin
                    out_req  = 1'b1;
                    out_byte = cur_data;
                    for (int k = 0; k < N_SRCS; k++) begin
                        sel[k] = bus.out_ack_i && (cur_src_q == IDX_W'(k));
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cur_src_q   <= '0;
            last_src_q  <= IDX_W'(N_SRCS - 1);
            burst_cnt_q <= '0;
            grant_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        cur_src_q   <= pick_idx;
                        burst_cnt_q <= '0;
                        grant_q     <= N_SRCS'(1) << pick_idx;
`ifdef OUT_SCHED_TAG_EN
                        state_q     <= ST_TAG;
`else
                        state_q     <= ST_SEND;
`endif
                    end
                end
`ifdef OUT_SCHED_TAG_EN
                ST_TAG: begin
                    if (bus.out_ack_i) begin
                        state_q <= ST_SEND;
                    end
                end
`endif
                ST_SEND: begin
                    // A released request or a full burst both hand the rotation onward.
                    if (!cur_req) begin
                        last_src_q <= cur_src_q;
                        state_q    <= ST_IDLE;
                        grant_q    <= '0;
                    end else if (bus.out_ack_i) begin
                        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                        if (last_beat) begin
                            last_src_q <= cur_src_q;
                            state_q    <= ST_IDLE;
                            grant_q    <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.out_req_o = out_req;
    assign bus.out_o     = out_byte;
    assign bus.src_sel_o = sel;
    assign bus.grant_o   = grant_q;
    assign bus.state_o   = state_q;
endmodule
